// File: rtl/rx_pkg.sv
// Shared types, default frame geometry and a width helper for the receiver sequencer.
package rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } rx_state_e;

  localparam int unsigned DefSamplesPerBit = 90;
  localparam int unsigned DefCarrierPeriod = 6;
  localparam int unsigned DefFrameBytes    = 6;

  // Bits needed to encode values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_frame_sequencer_if.sv
// Byte stream from the sequencer to the downstream consumer (valid/ready).
interface rx_frame_sequencer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/rx_byte_assembler.sv
// Packs correlator bit decisions LSB-first into bytes and holds each byte until accepted.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = DefFrameBytes,
  localparam int unsigned TotalBits  = FRAME_BYTES * 8,
  localparam int unsigned CntW       = clog2(TotalBits + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  bit_en_i,
  input  logic                  bit_valid_i,
  input  logic                  bit_value_i,
  output logic [CntW-1:0]       bit_cnt_o,
  output logic                  overflow_o,
  rx_frame_sequencer_if.master  byte_if
);

  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            accept, byte_done, xfer;
  logic [7:0]      shifted;

  // Next-state for the shift register, output byte, handshake and overflow.
  always_comb begin
    // Bits beyond one frame are ignored so the counter never wraps.
    accept             = bit_en_i & bit_valid_i & (bit_cnt_q < CntW'(TotalBits));
    shifted            = shift_q;
    shifted[bit_idx_q] = bit_value_i;
    byte_done          = accept & (bit_idx_q == 3'd7);
    xfer               = valid_q & byte_if.byte_ready;

    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;

    if (xfer) begin
      valid_d = 1'b0;
    end

    // A pending output byte survives a new start; only reset clears it.
    if (start_i) begin
      shift_d   = '0;
      bit_idx_d = '0;
      bit_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (accept) begin
      shift_d   = shifted;
      bit_idx_d = bit_idx_q + 3'd1;
      bit_cnt_d = bit_cnt_q + CntW'(1);
      if (byte_done) begin
        if (!valid_q || xfer) begin
          byte_d  = shifted;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      byte_q    <= '0;
      bit_idx_q <= '0;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign byte_if.byte_data  = byte_q;
  assign byte_if.byte_valid = valid_q;
  assign bit_cnt_o          = bit_cnt_q;
  assign overflow_o         = ovf_q;

endmodule

// File: rtl/rx_frame_sequencer.sv
// Frame sequencer: drives correlator window controls and hands decided bytes downstream.
module rx_frame_sequencer
  import rx_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = DefSamplesPerBit,
  parameter int unsigned CARRIER_PERIOD  = DefCarrierPeriod,
  parameter int unsigned FRAME_BYTES     = DefFrameBytes,
  parameter int unsigned PHASE_W         = 3
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 sync_in,
  output logic                 sync_out,
  output logic                 corr_clear,
  output logic                 corr_en,
  output logic [PHASE_W-1:0]   corr_phase,
  output logic                 corr_dump,
  input  logic                 bit_valid,
  input  logic                 bit_value,
  rx_frame_sequencer_if.master byte_if,
  output logic                 frame_done,
  output logic                 abort,
  output logic                 overflow
);

  localparam int unsigned TotalBits = FRAME_BYTES * 8;
  localparam int unsigned SampleW   = clog2(SAMPLES_PER_BIT);
  localparam int unsigned CntW      = clog2(TotalBits + 1);

  rx_state_e          state_q, state_d;
  logic               sync_prev_q, sync_prev_d;
  logic [SampleW-1:0] sample_cnt_q, sample_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CntW-1:0]    dump_cnt_q, dump_cnt_d;
  logic               abort_q, abort_d;
  logic               start, run, win_first, win_last;
  logic [CntW-1:0]    bit_cnt;

  // FSM next-state plus sample, phase and dump counters.
  always_comb begin
    sync_prev_d = sync_in;
    start       = (state_q == StIdle) & sync_in & ~sync_prev_q;
    run         = (state_q == StRun);
    win_first   = run & (sample_cnt_q == '0);
    win_last    = run & (sample_cnt_q == SampleW'(SAMPLES_PER_BIT - 1));

    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    phase_d      = phase_q;
    dump_cnt_d   = dump_cnt_q;
    abort_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          sample_cnt_d = '0;
          phase_d      = '0;
          dump_cnt_d   = '0;
        end
      end
      StRun: begin
        if (!sync_in) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else begin
          sample_cnt_d = win_last ? '0 : sample_cnt_q + SampleW'(1);
          // Phase restarts with every window so clear always lines up with phase 0.
          phase_d = (win_last || phase_q == PHASE_W'(CARRIER_PERIOD - 1)) ?
                    '0 : phase_q + PHASE_W'(1);
          if (win_last) begin
            dump_cnt_d = dump_cnt_q + CntW'(1);
            if (dump_cnt_q == CntW'(TotalBits - 1)) begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (!sync_in) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (bit_cnt == CntW'(TotalBits)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      sync_prev_q  <= 1'b0;
      sample_cnt_q <= '0;
      phase_q      <= '0;
      dump_cnt_q   <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_prev_q  <= sync_prev_d;
      sample_cnt_q <= sample_cnt_d;
      phase_q      <= phase_d;
      dump_cnt_q   <= dump_cnt_d;
      abort_q      <= abort_d;
    end
  end

  rx_byte_assembler #(
    .FRAME_BYTES (FRAME_BYTES)
  ) u_byte_assembler (
    .clk_i       (clock),
    .rst_ni      (resetN),
    .start_i     (start),
    .bit_en_i    (state_q == StRun || state_q == StDrain),
    .bit_valid_i (bit_valid),
    .bit_value_i (bit_value),
    .bit_cnt_o   (bit_cnt),
    .overflow_o  (overflow),
    .byte_if     (byte_if)
  );

  assign sync_out   = (state_q != StIdle);
  assign corr_en    = run;
  assign corr_clear = win_first;
  assign corr_dump  = win_last;
  assign corr_phase = run ? phase_q : '0;
  assign frame_done = (state_q == StDone);
  assign abort      = abort_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer with a latency-2 correlator model.
module tb_rx_frame_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       sync_in;
  logic       sync_out, corr_clear, corr_en, corr_dump, frame_done, abort, overflow;
  logic [2:0] corr_phase;
  logic       bit_valid, bit_value;
  logic       t_valid, t_value;

  rx_frame_sequencer_if byte_if ();

  rx_frame_sequencer dut (
    .clock      (clock),
    .resetN     (resetN),
    .sync_in    (sync_in),
    .sync_out   (sync_out),
    .corr_clear (corr_clear),
    .corr_en    (corr_en),
    .corr_phase (corr_phase),
    .corr_dump  (corr_dump),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .byte_if    (byte_if),
    .frame_done (frame_done),
    .abort      (abort),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Correlator model: a decision two cycles after each dump, bits from the pattern.
  logic        model_en = 1'b0;
  logic [47:0] pattern;
  int          model_k = 0;
  logic        p0 = 1'b0, p1 = 1'b0, m_valid = 1'b0, m_value = 1'b0;

  always @(negedge clock) begin
    if (!model_en) model_k <= 0;
    else if (p1) model_k <= model_k + 1;
    m_valid <= model_en & p1;
    m_value <= model_en & p1 & ((model_k < 48) ? pattern[model_k] : 1'b0);
    p1 <= p0;
    p0 <= corr_dump;
  end

  assign bit_valid = m_valid | t_valid;
  assign bit_value = m_valid ? m_value : t_value;

  logic [18:0] out_vec;
  assign out_vec = {sync_out, corr_clear, corr_en, corr_phase, corr_dump, byte_if.byte_data,
                    byte_if.byte_valid, frame_done, abort, overflow};

  int n_checks, n_errors;
  int t0, rel, ndump, dump_bad, phase_bad, clear_cnt, sync_bad, abort_cnt;
  int done_rel, ovf_rel, first_vld_rel, bad;
  logic [7:0] first_vld_data;
  logic       ovf_at_start;
  logic [7:0] got[$];
  logic [7:0] exp_bytes[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise sync_in and observe until frame_done, or drop sync_in at stop_rel.
  task automatic run_frame(input int stop_rel);
    @(negedge clock);
    sync_in = 1'b1;
    t0 = cyc;
    got.delete();
    ndump = 0; dump_bad = 0; phase_bad = 0; clear_cnt = 0; sync_bad = 0; abort_cnt = 0;
    done_rel = -1; ovf_rel = -1; first_vld_rel = -1; first_vld_data = 8'h00;
    ovf_at_start = 1'b1;
    for (int i = 1; i <= 4400; i++) begin
      @(negedge clock);
      rel = cyc - t0;
      if (corr_dump) begin
        ndump++;
        if (rel != ndump * 90) dump_bad++;
      end
      if (rel <= 4320) begin
        if (!corr_en || corr_phase !== 3'(((rel - 1) % 90) % 6) ||
            corr_clear !== (((rel - 1) % 90) == 0) || corr_dump !== (((rel - 1) % 90) == 89))
          phase_bad++;
      end else if (corr_en || corr_clear || corr_dump) begin
        phase_bad++;
      end
      if (corr_clear) clear_cnt++;
      if (!sync_out) sync_bad++;
      if (abort) abort_cnt++;
      if (rel == 1) ovf_at_start = overflow;
      if (overflow && ovf_rel < 0) ovf_rel = rel;
      if (byte_if.byte_valid && first_vld_rel < 0) begin
        first_vld_rel  = rel;
        first_vld_data = byte_if.byte_data;
      end
      if (byte_if.byte_valid && byte_if.byte_ready) got.push_back(byte_if.byte_data);
      if (frame_done) begin
        done_rel = rel;
        break;
      end
      if (rel == stop_rel) begin
        sync_in = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    resetN = 1'b0; sync_in = 1'b0; t_valid = 1'b0; t_value = 1'b0;
    byte_if.byte_ready = 1'b0;
    pattern = {8'h0f, 8'hf0, 8'haa, 8'h55, 8'h00, 8'hff};
    exp_bytes[0] = 8'hff; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h55;
    exp_bytes[3] = 8'haa; exp_bytes[4] = 8'hf0; exp_bytes[5] = 8'h0f;

    repeat (3) @(negedge clock);
    check("reset_outputs", 32'(out_vec), 0);
    resetN = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_after_reset", 32'(out_vec), 0);

    // Nominal frame, consumer always ready.
    model_en = 1'b1;
    byte_if.byte_ready = 1'b1;
    run_frame(-1);
    check("nom_done_rel", done_rel, 4324);
    check("nom_dumps", ndump, 48);
    check("nom_dump_spacing", dump_bad, 0);
    check("nom_phase_windows", phase_bad, 0);
    check("nom_clears", clear_cnt, 48);
    check("nom_sync_out", sync_bad, 0);
    check("nom_no_abort", abort_cnt, 0);
    check("nom_nbytes", got.size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < got.size()) check($sformatf("nom_byte%0d", j), 32'(got[j]), 32'(exp_bytes[j]));
    end
    @(negedge clock);
    check("nom_after_done", {sync_out, frame_done, byte_if.byte_valid}, 0);
    model_en = 1'b0;

    // sync_in held high after the frame must not restart.
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (sync_out) bad++;
    end
    check("no_restart_on_level", bad, 0);
    sync_in = 1'b0;
    @(negedge clock);

    // Bit strobes in IDLE are ignored.
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      t_valid = 1'b1;
      t_value = k[0];
      @(negedge clock);
      t_valid = 1'b0;
      if (byte_if.byte_valid) bad++;
      @(negedge clock);
      if (byte_if.byte_valid) bad++;
    end
    check("idle_bits_ignored", bad, 0);

    // Backpressure for the whole frame.
    byte_if.byte_ready = 1'b0;
    model_en = 1'b1;
    run_frame(-1);
    check("bp_done_rel", done_rel, 4324);
    check("bp_first_valid_rel", first_vld_rel, 723);
    check("bp_first_valid_data", 32'(first_vld_data), 32'h ff);
    check("bp_overflow_rel", ovf_rel, 1443);
    check("bp_no_transfers", got.size(), 0);
    @(negedge clock);
    check("bp_pending", {byte_if.byte_valid, byte_if.byte_data, overflow}, {1'b1, 8'hff, 1'b1});
    byte_if.byte_ready = 1'b1;
    @(negedge clock);
    check("bp_valid_after_accept", byte_if.byte_valid, 0);
    check("bp_overflow_sticky", overflow, 1);
    sync_in = 1'b0;
    model_en = 1'b0;
    @(negedge clock);

    // Abort at bit 20; the new start clears overflow.
    model_en = 1'b1;
    check("ovf_before_abort_frame", overflow, 1);
    run_frame(1803);
    check("ab_ovf_cleared", ovf_at_start, 0);
    check("ab_no_overflow", ovf_rel, -1);
    check("ab_bytes_before_abort", got.size(), 2);
    check("ab_no_done", done_rel, -1);
    @(negedge clock);
    check("ab_pulse_idle", {abort, sync_out, corr_en, corr_dump, corr_clear, corr_phase}, 8'h80);
    @(negedge clock);
    check("ab_pulse_width", abort, 0);
    model_en = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clock);
      if (frame_done || sync_out || byte_if.byte_valid) bad++;
    end
    check("ab_quiet", bad, 0);

    // Restart after abort: byte alignment must begin at bit 0 again.
    model_en = 1'b1;
    run_frame(-1);
    check("rs_ovf_at_start", ovf_at_start, 0);
    check("rs_done_rel", done_rel, 4324);
    check("rs_nbytes", got.size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < got.size()) check($sformatf("rs_byte%0d", j), 32'(got[j]), 32'(exp_bytes[j]));
    end
    @(negedge clock);
    sync_in = 1'b0;
    model_en = 1'b0;
    @(negedge clock);

    // Asynchronous reset in the middle of RUN with a byte pending.
    byte_if.byte_ready = 1'b0;
    model_en = 1'b1;
    @(negedge clock);
    sync_in = 1'b1;
    repeat (1000) @(negedge clock);
    check("rr_before_reset", {sync_out, corr_en, byte_if.byte_valid}, 3'b111);
    #2;
    resetN = 1'b0;
    sync_in = 1'b0;
    #1;
    check("rr_async_clear", 32'(out_vec), 0);
    @(negedge clock);
    resetN = 1'b1;
    model_en = 1'b0;
    repeat (3) @(negedge clock);
    check("rr_idle_after", 32'(out_vec), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
